// File: rtl/counter_dispatcher.sv
// counter_dispatcher: pops customers from a first-word-fall-through FIFO and
// loads each one into a free service counter, which then counts its service
// time down to zero.
// Build option: define RR_ARB_EN for round-robin grant. Without it the lowest
// free counter index wins. The port list is the same in both builds.

// One service counter: FREE -> SERVING on load, SERVING -> FREE when rem hits 1.
module counter_dispatcher_lane #(
    parameter int NUM_W = 4,
    parameter int TIM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NUM_W-1:0] num_in,
    input  logic [TIM_W-1:0] tim_in,
    output logic             ld,
    output logic             busy,
    output logic [NUM_W-1:0] num,
    output logic [TIM_W-1:0] rem,
    output logic             done
);
    // This counter completes at the coming edge.
    assign done = busy && (rem == TIM_W'(1));

    // Load, countdown and release of one counter. A zero service time is
    // served as one cycle so every customer occupies the counter at least once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld   <= 1'b0;
            busy <= 1'b0;
            num  <= '0;
            rem  <= '0;
        end else begin
            ld <= load;
            if (load) begin
                busy <= 1'b1;
                num  <= num_in;
                rem  <= (tim_in == '0) ? TIM_W'(1) : tim_in;
            end else if (busy) begin
                if (done) begin
                    busy <= 1'b0;
                    num  <= '0;
                    rem  <= '0;
                end else begin
                    rem <= rem - TIM_W'(1);
                end
            end
        end
    end
endmodule

module counter_dispatcher #(
    parameter int N_CNT = 3,
    parameter int NUM_W = 4,
    parameter int TIM_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_emp,
    input  logic [NUM_W-1:0]       fifo_num,
    input  logic [TIM_W-1:0]       fifo_tim,
    output logic                   fifo_re,
    output logic [N_CNT-1:0]       ld,
    output logic [N_CNT-1:0]       busy,
    output logic [N_CNT*NUM_W-1:0] num_out,
    output logic [N_CNT*TIM_W-1:0] rem_out,
    output logic [7:0]             served
);
    logic [N_CNT-1:0] free;
    logic [N_CNT-1:0] gnt;
    logic [N_CNT-1:0] load;
    logic [N_CNT-1:0] done;
    logic [3:0]       n_done;
    logic [8:0]       served_sum;
    logic             found;

    // Free set comes from registered state only, so a counter finishing at an
    // edge is not grantable until the following cycle.
    assign free    = ~busy;
    assign fifo_re = !rst && !fifo_emp && (free != '0);
    assign load    = fifo_re ? gnt : '0;

`ifdef RR_ARB_EN
    localparam int PTR_W = (N_CNT > 1) ? $clog2(N_CNT) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;

    // Round-robin pick: first free counter at or after ptr, else wrap to the
    // lowest free one (which is necessarily below ptr).
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            if (!found && free[i] && (PTR_W'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                gidx   = PTR_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_CNT; i++) begin
            if (!found && free[i]) begin
                gnt[i] = 1'b1;
                gidx   = PTR_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Advance the pointer past the counter just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (fifo_re) begin
            ptr <= (gidx == PTR_W'(N_CNT - 1)) ? '0 : gidx + PTR_W'(1);
        end
    end
`else
    // Fixed priority pick: lowest free index.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            if (!found && free[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_lane
            counter_dispatcher_lane #(
                .NUM_W (NUM_W),
                .TIM_W (TIM_W)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .load   (load[gi]),
                .num_in (fifo_num),
                .tim_in (fifo_tim),
                .ld     (ld[gi]),
                .busy   (busy[gi]),
                .num    (num_out[gi*NUM_W +: NUM_W]),
                .rem    (rem_out[gi*TIM_W +: TIM_W]),
                .done   (done[gi])
            );
        end
    endgenerate

    // Number of counters completing at the coming edge.
    always_comb begin
        n_done = '0;
        for (int i = 0; i < N_CNT; i++) begin
            n_done = n_done + 4'(done[i]);
        end
    end

    assign served_sum = {1'b0, served} + 9'(n_done);

    // Completed-customer count, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            served <= '0;
        end else begin
            served <= served_sum[8] ? 8'hFF : served_sum[7:0];
        end
    end
endmodule

// File: tb/tb_counter_dispatcher.sv
// Bench for counter_dispatcher: a small FWFT FIFO feeds the DUT, every pushed
// customer also pushes its expected (counter, number, time) onto a scoreboard
// that is popped whenever the DUT pulses ld. Works with or without RR_ARB_EN.
module tb_counter_dispatcher;
    localparam int N_CNT = 3;
    localparam int NUM_W = 4;
    localparam int TIM_W = 4;

    typedef struct {
        int         idx;
        logic [3:0] num;
        logic [3:0] rem;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   fifo_emp;
    logic [NUM_W-1:0]       fifo_num;
    logic [TIM_W-1:0]       fifo_tim;
    logic                   fifo_re;
    logic [N_CNT-1:0]       ld;
    logic [N_CNT-1:0]       busy;
    logic [N_CNT*NUM_W-1:0] num_out;
    logic [N_CNT*TIM_W-1:0] rem_out;
    logic [7:0]             served;

    logic [3:0] mem_num [0:511];
    logic [3:0] mem_tim [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [8:0] rd_a;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    counter_dispatcher #(.N_CNT(N_CNT), .NUM_W(NUM_W), .TIM_W(TIM_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_emp (fifo_emp),
        .fifo_num (fifo_num),
        .fifo_tim (fifo_tim),
        .fifo_re  (fifo_re),
        .ld       (ld),
        .busy     (busy),
        .num_out  (num_out),
        .rem_out  (rem_out),
        .served   (served)
    );

    always #5 clk = ~clk;

    assign rd_a     = rd_ptr[8:0];
    assign fifo_emp = (rd_ptr == wr_ptr);
    assign fifo_num = mem_num[rd_a];
    assign fifo_tim = mem_tim[rd_a];

    // FIFO pop: advance the head just after the edge that consumed it.
    always @(posedge clk) begin
        if (fifo_re) begin
            #1;
            rd_ptr = rd_ptr + 1;
        end
    end

    // Scoreboard: every ld pulse must match the next expected load.
    always @(negedge clk) begin
        if (ld !== '0) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ld: ld=%b, required no load", ld);
            end else begin
                mon_e = exp_q.pop_front();
                if (ld !== (3'b001 << mon_e.idx) ||
                    num_out[mon_e.idx*NUM_W +: NUM_W] !== mon_e.num ||
                    rem_out[mon_e.idx*TIM_W +: TIM_W] !== mon_e.rem) begin
                    n_fail++;
                    $display("FAIL sb_load: ld=%b num=%0d rem=%0d, required ctr=%0d num=%0d rem=%0d",
                             ld, num_out[mon_e.idx*NUM_W +: NUM_W],
                             rem_out[mon_e.idx*TIM_W +: TIM_W],
                             mon_e.idx, mon_e.num, mon_e.rem);
                end
            end
        end
    end

    task automatic push(input int num, input int tim, input int idx);
        exp_t e;
        mem_num[wr_ptr % 512] = 4'(num);
        mem_tim[wr_ptr % 512] = 4'(tim);
        wr_ptr = wr_ptr + 1;
        e.idx = idx;
        e.num = 4'(num);
        e.rem = (tim == 0) ? 4'd1 : 4'(tim);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push(1, 3, 0);
        push(2, 2, 1);
        push(3, 4, 2);
        repeat (3) begin
            @(negedge clk);
            n_assert++;
            if ({fifo_re, ld, busy, num_out, rem_out, served} !== '0) begin
                n_fail++;
                $display("FAIL reset_state: re=%b ld=%b busy=%b num=%h rem=%h served=%0d, required all 0",
                         fifo_re, ld, busy, num_out, rem_out, served);
            end
        end
        rst = 1'b0;
        #1;
        n_assert++;
        if (fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_pop: fifo_re=%b, required 1", fifo_re);
        end
    endtask

    task automatic test_basic();
        logic [2:0] tb_busy [1:7] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b100, 3'b100, 3'b000};
        logic [7:0] tb_srv  [1:7] = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd3};
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_assert++;
            if (busy !== tb_busy[c] || served !== tb_srv[c]) begin
                n_fail++;
                $display("FAIL basic_c%0d: busy=%b served=%0d, required busy=%b served=%0d",
                         c, busy, served, tb_busy[c], tb_srv[c]);
            end
            if (c == 3) begin
                n_assert++;
                if (num_out !== 12'h321 || rem_out !== 12'h411) begin
                    n_fail++;
                    $display("FAIL basic_slices: num=%h rem=%h, required num=321 rem=411", num_out, rem_out);
                end
            end
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_timeout: %0d loads pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_all_busy();
        logic [2:0] tb_busy [1:9] = '{3'b001, 3'b011, 3'b111, 3'b101, 3'b111, 3'b100, 3'b100, 3'b100, 3'b000};
        logic       tb_re   [1:9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] tb_srv  [1:9] = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd6, 8'd6, 8'd6, 8'd7};
        push(6, 5, 0);
        push(7, 2, 1);
        push(8, 6, 2);
        push(4, 1, 1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_assert++;
            if (busy !== tb_busy[c] || fifo_re !== tb_re[c] || served !== tb_srv[c]) begin
                n_fail++;
                $display("FAIL all_busy_c%0d: busy=%b re=%b served=%0d, required busy=%b re=%b served=%0d",
                         c, busy, fifo_re, served, tb_busy[c], tb_re[c], tb_srv[c]);
            end
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL all_busy_timeout: %0d loads pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_time();
`ifdef RR_ARB_EN
        int idx = 2;
`else
        int idx = 0;
`endif
        push(5, 0, idx);
        @(negedge clk);
        n_assert++;
        if (busy !== (3'b001 << idx) || rem_out[idx*TIM_W +: TIM_W] !== 4'd1) begin
            n_fail++;
            $display("FAIL zero_time_load: busy=%b rem=%h, required busy=%b rem=1",
                     busy, rem_out, 3'b001 << idx);
        end
        @(negedge clk);
        n_assert++;
        if (busy !== 3'b000 || served !== 8'd8) begin
            n_fail++;
            $display("FAIL zero_time_done: busy=%b served=%0d, required busy=000 served=8", busy, served);
        end
    endtask

    task automatic test_arb();
        logic [2:0] tb_busy [1:6] = '{3'b001, 3'b011, 3'b110, 3'b111, 3'b101, 3'b000};
        logic [7:0] tb_srv  [1:6] = '{8'd8, 8'd8, 8'd9, 8'd9, 8'd10, 8'd12};
        push(9, 2, 0);
        push(10, 3, 1);
        push(11, 3, 2);
        push(12, 2, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_assert++;
            if (busy !== tb_busy[c] || served !== tb_srv[c]) begin
                n_fail++;
                $display("FAIL arb_c%0d: busy=%b served=%0d, required busy=%b served=%0d",
                         c, busy, served, tb_busy[c], tb_srv[c]);
            end
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL arb_timeout: %0d loads pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_saturate();
        int exp_srv;
        for (int k = 0; k < 300; k++) begin
`ifdef RR_ARB_EN
            push(k % 16, 1, (1 + k) % 3);
`else
            push(k % 16, 1, k % 2);
`endif
        end
        for (int c = 1; c <= 302; c++) begin
            @(negedge clk);
            exp_srv = 12 + ((c - 1 > 300) ? 300 : c - 1);
            if (exp_srv > 255) exp_srv = 255;
            n_assert++;
            if (served !== 8'(exp_srv)) begin
                n_fail++;
                $display("FAIL saturate_c%0d: served=%0d, required %0d", c, served, exp_srv);
            end
        end
        n_assert++;
        if (exp_q.size() != 0 || busy !== 3'b000) begin
            n_fail++;
            $display("FAIL saturate_end: pending=%0d busy=%b, required 0 and 000", exp_q.size(), busy);
        end
    endtask

    task automatic test_mid_reset();
`ifdef RR_ARB_EN
        logic [2:0] exp_busy = 3'b110;
        push(13, 5, 1);
        push(14, 5, 2);
`else
        logic [2:0] exp_busy = 3'b011;
        push(13, 5, 0);
        push(14, 5, 1);
`endif
        repeat (2) @(negedge clk);
        n_assert++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL mid_reset_pre: busy=%b, required %b", busy, exp_busy);
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if (fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_re: fifo_re=%b, required 0", fifo_re);
        end
        @(negedge clk);
        n_assert++;
        if ({ld, busy, num_out, rem_out, served} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: ld=%b busy=%b num=%h rem=%h served=%0d, required all 0",
                     ld, busy, num_out, rem_out, served);
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (busy !== 3'b000 || fifo_re !== 1'b0 || served !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: busy=%b re=%b served=%0d, required 000 0 0", busy, fifo_re, served);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_busy();
        test_zero_time();
        test_arb();
        test_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
